// File: rtl/keypad_pkg.sv
// Shared types, default parameters and the key-code helper for the keypad scanner.
package keypad_pkg;

    localparam int unsigned DEF_NUM_ROWS       = 4;
    localparam int unsigned DEF_NUM_COLS       = 4;
    localparam int unsigned DEF_SCAN_DIV       = 256;
    localparam int unsigned DEF_DEBOUNCE_SCANS = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    // Linear key index for a (row, col) position.
    function automatic int unsigned key_code_f(input int unsigned row,
                                               input int unsigned col,
                                               input int unsigned num_cols);
        return row * num_cols + col;
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchroniser for the raw keypad column inputs.
// Ports: clk, reset (async active-low), async_in (raw columns), sync_out (synchronised).
// Resets to all ones, matching the idle (pulled-up) column level.
module keypad_col_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row rotation, per-tick column sampling, press/release
// debounce, key encoding and a valid/ready delivery register with sticky overrun.
// Ports: clk, reset (async active-low), keypad_rows (one-hot-low drive),
//        keypad_cols (raw columns), key_code/key_valid/key_ready (handshake),
//        key_held (confirmed key still down), overrun (sticky dropped press).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter  int unsigned NUM_ROWS       = DEF_NUM_ROWS,
    parameter  int unsigned NUM_COLS       = DEF_NUM_COLS,
    parameter  int unsigned SCAN_DIV       = DEF_SCAN_DIV,
    parameter  int unsigned DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
    localparam int unsigned CODE_W         = $clog2(NUM_ROWS * NUM_COLS)
) (
    input  logic                clk,
    input  logic                reset,
    output logic [NUM_ROWS-1:0] keypad_rows,
    input  logic [NUM_COLS-1:0] keypad_cols,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                key_held,
    output logic                overrun
);

    localparam int unsigned ROW_W = $clog2(NUM_ROWS);
    localparam int unsigned COL_W = $clog2(NUM_COLS);
    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [NUM_COLS-1:0] cols_sync;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [NUM_ROWS-1:0] rows_q, rows_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [DEB_W-1:0]    deb_q, deb_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                valid_q, valid_d;
    logic                held_q, held_d;
    logic                ovr_q, ovr_d;

    logic                tick_c;
    logic                any_low_c;
    logic [COL_W-1:0]    low_col_c;
    logic                col_high_c;
    logic                confirm_c;
    logic                advance_c;

    keypad_col_sync #(.WIDTH(NUM_COLS)) u_col_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (keypad_cols),
        .sync_out (cols_sync)
    );

    // Scan-rate tick generator.
    always_comb begin
        tick_c = (cnt_q == CNT_W'(SCAN_DIV - 1));
        cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
    end

    // Lowest-index low column wins when several are pressed on one row.
    always_comb begin
        low_col_c = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (!cols_sync[i]) low_col_c = COL_W'(i);
        end
        any_low_c  = ~&cols_sync;
        col_high_c = cols_sync[col_q];
    end

    // Scan / debounce / held / release FSM; only acts on ticks.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        deb_d     = deb_q;
        confirm_c = 1'b0;
        advance_c = 1'b0;
        if (tick_c) begin
            case (state_q)
                SCAN: begin
                    if (any_low_c) begin
                        col_d = low_col_c;
                        deb_d = DEB_W'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d   = HELD;
                            confirm_c = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        advance_c = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!col_high_c) begin
                        deb_d = deb_q + DEB_W'(1);
                        if (deb_q + DEB_W'(1) >= DEB_W'(DEBOUNCE_SCANS)) begin
                            state_d   = HELD;
                            confirm_c = 1'b1;
                        end
                    end else begin
                        state_d   = SCAN;
                        deb_d     = '0;
                        advance_c = 1'b1;
                    end
                end
                HELD: begin
                    if (col_high_c) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d   = SCAN;
                            deb_d     = '0;
                            advance_c = 1'b1;
                        end else begin
                            state_d = RELEASE;
                            deb_d   = DEB_W'(1);
                        end
                    end
                end
                RELEASE: begin
                    if (col_high_c) begin
                        if (deb_q + DEB_W'(1) >= DEB_W'(DEBOUNCE_SCANS)) begin
                            state_d   = SCAN;
                            deb_d     = '0;
                            advance_c = 1'b1;
                        end else begin
                            deb_d = deb_q + DEB_W'(1);
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    // Row rotation; the row stays frozen while a key is being tracked.
    always_comb begin
        row_d = row_q;
        if (advance_c) begin
            row_d = (row_q == ROW_W'(NUM_ROWS - 1)) ? '0 : row_q + ROW_W'(1);
        end
        rows_d = ~(NUM_ROWS'(1) << row_d);
    end

    // Delivery register: a confirmed press loads unless an undelivered code is
    // still waiting, in which case it is dropped and flagged.
    always_comb begin
        code_d  = code_q;
        valid_d = valid_q & ~key_ready;
        ovr_d   = ovr_q;
        held_d  = (state_d == HELD) || (state_d == RELEASE);
        if (confirm_c) begin
            if (!valid_q || key_ready) begin
                code_d  = CODE_W'(key_code_f(32'(row_q), 32'(col_d), NUM_COLS));
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SCAN;
            cnt_q   <= '0;
            row_q   <= '0;
            rows_q  <= ~NUM_ROWS'(1);
            col_q   <= '0;
            deb_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            rows_q  <= rows_d;
            col_q   <= col_d;
            deb_q   <= deb_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
            ovr_q   <= ovr_d;
        end
    end

    assign keypad_rows = rows_q;
    assign key_code    = code_q;
    assign key_valid   = valid_q;
    assign key_held    = held_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, tick-level reference model with
// a per-cycle compare, directed scenarios with literal expectations, random presses.
`timescale 1ns/1ps
module tb_keypad_scanner;

    localparam int unsigned NR = 4;
    localparam int unsigned NC = 4;
    localparam int unsigned SD = 4;
    localparam int unsigned DB = 3;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  keypad_rows;
    logic [3:0]  keypad_cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready = 1'b1;
    logic        key_held;
    logic        overrun;

    logic [15:0] pressed_v = '0;   // bit r*NC+c = key (r,c) physically down

    int n_tests = 0;
    int n_fail  = 0;
    bit running = 1'b0;

    keypad_scanner #(
        .NUM_ROWS       (NR),
        .NUM_COLS       (NC),
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .keypad_rows (keypad_rows),
        .keypad_cols (keypad_cols),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_held    (key_held),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Physical keypad: a column reads low only while a pressed key's row is driven low.
    always_comb begin
        keypad_cols = '1;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (!keypad_rows[r] && pressed_v[r*NC+c]) keypad_cols[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the scan at tick granularity: which row is active, which key is being
    // followed, how many agreeing ticks have been seen, and the delivery slot.
    int         m_cnt, m_row, m_col, m_agree, m_phase, m_code;  // phase: 0 idle,1 pressing,2 down,3 lifting
    bit         m_valid, m_held, m_ovr, m_conf, m_tick;
    logic [3:0] m_s1, m_s2, m_samp;

    function automatic logic [3:0] model_cols(input int row);
        logic [3:0] v = '1;
        for (int c = 0; c < NC; c++) if (pressed_v[row*NC+c]) v[c] = 1'b0;
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt = 0; m_row = 0; m_col = 0; m_agree = 0; m_phase = 0; m_code = 0;
            m_valid = 0; m_held = 0; m_ovr = 0; m_s1 = '1; m_s2 = '1;
        end else begin
            m_samp = m_s2;
            m_tick = (m_cnt == SD - 1);
            m_conf = 0;
            m_s2   = m_s1;
            m_s1   = model_cols(m_row);
            m_cnt  = (m_cnt + 1) % SD;
            if (m_tick) begin
                if (m_phase == 0) begin
                    if (m_samp != 4'hF) begin
                        for (int c = NC - 1; c >= 0; c--) if (!m_samp[c]) m_col = c;
                        m_agree = 1;
                        m_phase = 1;
                        if (m_agree >= DB) begin m_conf = 1; m_phase = 2; end
                    end else m_row = (m_row + 1) % NR;
                end else if (m_phase == 1) begin
                    if (!m_samp[m_col]) begin
                        m_agree++;
                        if (m_agree >= DB) begin m_conf = 1; m_phase = 2; end
                    end else begin
                        m_phase = 0; m_row = (m_row + 1) % NR;
                    end
                end else if (m_phase == 2) begin
                    if (m_samp[m_col]) begin m_agree = 1; m_phase = 3; end
                end else begin
                    if (m_samp[m_col]) begin
                        m_agree++;
                        if (m_agree >= DB) begin m_phase = 0; m_row = (m_row + 1) % NR; end
                    end else m_phase = 2;
                end
            end
            if (m_valid && key_ready) m_valid = 0;
            if (m_conf) begin
                if (!m_valid) begin m_valid = 1; m_code = m_row * NC + m_col; end
                else m_ovr = 1;
            end
            m_held = (m_phase >= 2);
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [3:0] one4 = 4'b0001;
    logic [3:0] exp_rows;
    logic [3:0] xfers[$];
    int         n_rise = 0;
    logic       prev_valid = 1'b0;

    always @(negedge clk) begin
        if (running) begin
            exp_rows = ~(one4 << m_row);
            check("outputs{rows,valid,code,held,ovr}",
                  {21'd0, keypad_rows, key_valid, key_code, key_held, overrun},
                  {21'd0, exp_rows, m_valid, 4'(m_code), m_held, m_ovr});
            if (key_valid && key_ready) xfers.push_back(key_code);
            if (key_valid && !prev_valid) n_rise++;
            prev_valid = key_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        return (sel == 0) ? key_valid : key_held;
    endfunction

    task automatic wait_sig(input string name, input int sel, input logic lvl, input int max);
        int n = 0;
        while (sig(sel) !== lvl && n < max) begin cyc(1); n++; end
        check(name, 32'(sig(sel)), 32'(lvl));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rows"},  32'(keypad_rows), 32'h0000_000E);
        check({name, "_code"},  32'(key_code),    32'h0);
        check({name, "_valid"}, 32'(key_valid),   32'h0);
        check({name, "_held"},  32'(key_held),    32'h0);
        check({name, "_ovr"},   32'(overrun),     32'h0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish (got running expected done)");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_rot[5];
        int         snap, first, k;
        exp_rot[0] = 4'b1110; exp_rot[1] = 4'b1101; exp_rot[2] = 4'b1011;
        exp_rot[3] = 4'b0111; exp_rot[4] = 4'b1110;

        running = 1'b1;
        cyc(3);
        reset = 1'b1;
        cyc(21);

        // Reset mid-run, then row rotation from row 0.
        reset = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        cyc(2);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rotation_%0d", i), 32'(keypad_rows), 32'(exp_rot[i]));
            cyc(SD);
        end

        // Single press (2,1) with ready high: one-cycle pulse of code 9.
        key_ready = 1'b1;
        pressed_v = 16'(1) << 9;
        wait_sig("single_valid", 0, 1'b1, 200);
        check("single_code", 32'(key_code), 32'd9);
        check("single_held", 32'(key_held), 32'd1);
        cyc(1);
        check("single_pulse_end", 32'(key_valid), 32'd0);
        pressed_v = '0;
        wait_sig("single_release", 1, 1'b0, 200);
        check("single_resume_row3", 32'(keypad_rows), 32'h7);

        // Bounce: alternate the contact every tick, never three agreeing ticks.
        snap = n_rise;
        for (int i = 0; i < 12; i++) begin
            pressed_v = (i % 2 == 0) ? (16'(1) << 6) : 16'(0);
            cyc(SD);
        end
        pressed_v = '0;
        cyc(40);
        check("bounce_no_valid", 32'(n_rise - snap), 32'd0);
        check("bounce_not_held", 32'(key_held), 32'd0);

        // Two keys on row 1: only the first one (code 7) is reported.
        xfers.delete();
        pressed_v = 16'(1) << 7;
        wait_sig("two_first_held", 1, 1'b1, 200);
        pressed_v = pressed_v | (16'(1) << 4);
        cyc(60);
        pressed_v = '0;
        wait_sig("two_release", 1, 1'b0, 200);
        cyc(40);
        first = (xfers.size() > 0) ? int'(xfers[0]) : 99;
        check("two_xfer_count", 32'(xfers.size()), 32'd1);
        check("two_xfer_code", 32'(first), 32'd7);

        // Overrun: code 5 waiting, code 10 dropped.
        xfers.delete();
        key_ready = 1'b0;
        pressed_v = 16'(1) << 5;
        wait_sig("ovr_first_valid", 0, 1'b1, 200);
        pressed_v = '0;
        wait_sig("ovr_first_release", 1, 1'b0, 200);
        pressed_v = 16'(1) << 10;
        wait_sig("ovr_second_held", 1, 1'b1, 200);
        check("ovr_valid_kept", 32'(key_valid), 32'd1);
        check("ovr_code_kept", 32'(key_code), 32'd5);
        check("ovr_flag", 32'(overrun), 32'd1);
        pressed_v = '0;
        wait_sig("ovr_second_release", 1, 1'b0, 200);
        key_ready = 1'b1;
        cyc(1);
        check("ovr_drained", 32'(key_valid), 32'd0);
        first = (xfers.size() > 0) ? int'(xfers[0]) : 99;
        check("ovr_xfer_count", 32'(xfers.size()), 32'd1);
        check("ovr_xfer_code", 32'(first), 32'd5);

        // Reset during debounce of key (0,0).
        reset = 1'b0;
        pressed_v = 16'(1);
        cyc(2);
        reset = 1'b1;
        cyc(6);
        reset = 1'b0;
        #1;
        check_reset_outputs("deb_reset");
        pressed_v = '0;
        cyc(2);
        reset = 1'b1;
        snap = n_rise;
        cyc(60);
        check("deb_reset_no_event", 32'(n_rise - snap), 32'd0);
        check("deb_reset_not_held", 32'(key_held), 32'd0);

        // Reset while a code is waiting.
        key_ready = 1'b0;
        pressed_v = 16'(1) << 6;
        wait_sig("pend_valid", 0, 1'b1, 200);
        reset = 1'b0;
        #1;
        check_reset_outputs("pend_reset");
        pressed_v = '0;
        cyc(2);
        reset = 1'b1;
        snap = n_rise;
        cyc(60);
        check("pend_reset_no_event", 32'(n_rise - snap), 32'd0);
        check("pend_reset_valid", 32'(key_valid), 32'd0);

        // Random presses, bounces, extra keys and consumer stalls.
        for (int it = 0; it < 40; it++) begin
            k = int'($urandom % 16);
            key_ready = 1'($urandom % 2);
            pressed_v = 16'(1) << k;
            if ($urandom % 4 == 0) pressed_v = pressed_v | (16'(1) << ($urandom % 16));
            if ($urandom % 3 == 0) begin
                for (int b = 0; b < 6; b++) begin
                    pressed_v = pressed_v ^ (16'(1) << k);
                    cyc(int'($urandom_range(1, 6)));
                end
                pressed_v = pressed_v | (16'(1) << k);
            end
            cyc(int'($urandom_range(5, 120)));
            key_ready = 1'($urandom % 2);
            pressed_v = '0;
            cyc(int'($urandom_range(5, 80)));
        end
        key_ready = 1'b1;
        cyc(60);

        running = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner with debounce, key encoding and a valid/ready output handshake. It drives one keypad row low at a time and samples the synchronised column inputs at a programmable scan rate. One press is confirmed only after a programmable number of stable samples, and is then delivered to downstream logic (display or lock FSM) as a binary key code. It replaces raw row/column debug scanning in the top level and is clocked from the internal HSOSC-derived clock.

## Interface
- NUM_ROWS, 4, keypad rows driven; ≥2
- NUM_COLS, 4, keypad columns read; ≥2
- SCAN_DIV, 256, clk cycles per scan tick (row dwell time); ≥4
- DEBOUNCE_SCANS, 4, consecutive agreeing ticks to confirm press or release; ≥1
- CODE_W, $clog2(NUM_ROWS*NUM_COLS), derived, not overridden
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- keypad_rows  out  NUM_ROWS  one-hot-low row drive
- keypad_cols  in  NUM_COLS  raw asynchronous columns; pulled up, 0 = pressed on the driven row
- key_code  out  CODE_W  row*NUM_COLS + col of confirmed key
- key_valid  out  1  key_code holds an undelivered press
- key_ready  in  1  consumer accepts key_code when key_valid=1
- key_held  out  1  the confirmed key is still down
- overrun  out  1  sticky: a press was dropped because key_valid was pending

## Operation
- Columns pass through a 2-flop synchroniser. All decisions use the synchronised value.
- The tick counter counts 0..SCAN_DIV-1 and wraps. A tick is the cycle where count = SCAN_DIV-1.
- The FSM has four states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - On each tick, if any column is low, latch the lowest-index low column and go to DEBOUNCE with debounce count = 1. The current row stays frozen.
  - If all columns are high, rotate to the next row, wrapping NUM_ROWS-1 → 0.
- DEBOUNCE:
  - On each tick, if the latched column is still low, increment the count.
  - When the count reaches DEBOUNCE_SCANS, confirm the press and go to HELD.
  - If the latched column is high, return to SCAN and advance the row.
  - When DEBOUNCE_SCANS = 1, the press is confirmed on the detecting tick itself.
- HELD:
  - key_held = 1.
  - On a tick where the latched column is high, go to RELEASE with count = 1.
- RELEASE:
  - key_held stays 1.
  - A tick with the column still high increments the count. At DEBOUNCE_SCANS, clear key_held, go to SCAN and advance the row.
  - A tick with the column low returns to HELD.
- Additional keys pressed while in DEBOUNCE, HELD or RELEASE are ignored. No rollover.
- Confirmed-press handling:
  - If key_valid = 0, or the same cycle completes a transfer (key_valid & key_ready), load key_code and set key_valid.
  - Otherwise drop the press, set overrun, and leave key_code unchanged.
- Transfer occurs on key_valid & key_ready. key_valid clears on the next cycle unless a new press loads in the same cycle.
- overrun clears only on reset.

## Timing
- Reset values:
  - keypad_rows = all ones except bit 0 = 0
  - key_code = 0, key_valid = 0, key_held = 0, overrun = 0
  - state = SCAN, tick counter = 0, debounce count = 0
- An asserted reset aborts any state immediately. There is no pending-event carry-over.
- keypad_rows is registered and changes the cycle after a rotating tick. Each row therefore dwells SCAN_DIV cycles before sampling, which covers settling plus 2 synchroniser cycles.
- key_valid and key_code update one cycle after the confirming tick. key_held rises on the same cycle.
- key_code stays stable while key_valid = 1 and no transfer has occurred.
- Minimum press-to-key_valid latency is 2 sync + (DEBOUNCE_SCANS-1)*SCAN_DIV + 1 cycles after the first sampling tick.
- key_ready is ignored while key_valid = 0.

## Structure
- Package keypad_pkg holds:
  - the state enum typedef (SCAN, DEBOUNCE, HELD, RELEASE)
  - default parameter constants
  - a key-code function (row, col) → row*NUM_COLS + col
- Sub-module keypad_col_sync: a parametrised NUM_COLS-wide 2-flop synchroniser with asynchronous active-low reset to all ones.
- Top scanner: tick counter, row register, FSM, debounce counter, output/handshake register.

## Test plan
Bench parameters: NUM_ROWS = 4, NUM_COLS = 4, SCAN_DIV = 4, DEBOUNCE_SCANS = 3. The keypad model pulls a column low only while its row is driven low.
- Reset: reset = 0 mid-run → keypad_rows = 4'b1110, all outputs 0. Release reset → rows rotate 1110 → 1101 → 1011 → 0111 → 1110, 4 cycles each.
- Single press, row 2 col 1, key_ready = 1:
  - key_valid pulses for 1 cycle with key_code = 9.
  - key_held stays 1 until 3 high ticks after release.
  - Scanning then resumes at row 3.
- Bounce: column low for 1 tick, high for 1 tick, repeated → no key_valid. Scanning resumes.
- Two keys, (1,3) then (1,0) while the first is held → only code 7 is reported. Code 4 is never reported.
- Overrun, key_ready = 0: press and release code 5, then press code 10 → key_valid stays 1 with key_code = 5 and overrun = 1. Then key_ready = 1 → one transfer of 5 and key_valid = 0.
- Reset asserted during DEBOUNCE, or while key_valid = 1 → all outputs return to reset values immediately. No event after reset deassertion while the key is released.
